// File: rtl/vga_timing_pkg.sv
// Shared timing defaults (640x480@60), colour packing helpers and the
// count-domain sync/de bundle carried through the alignment delay line.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;
    localparam int COLOR_W_DEF  = 2;

    // Channel index times COLOR_W gives the LSB of that channel in {r,g,b}.
    typedef enum int {
        CH_B = 0,
        CH_G = 1,
        CH_R = 2
    } rgb_chan_e;

    function automatic int chan_lsb(input rgb_chan_e chan, input int color_w);
        return int'(chan) * color_w;
    endfunction

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

endpackage

// File: rtl/vga_delay_line.sv
// Enable-qualified shift register with async reset; DEPTH=0 is a plain wire.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign o_q = i_d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
                end else if (i_en) begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: counters, strobes, renderer-latency
// alignment of sync/de, and a blanked, registered colour output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int PIPE_LAT = 0,
    parameter int FRAME_W  = 8,
    parameter int COLOR_W  = COLOR_W_DEF,
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    output logic [HW-1:0]        h_count,
    output logic [VW-1:0]        v_count,
    output logic [FRAME_W-1:0]   frame,
    output logic                 line_start,
    output logic                 frame_start,
    input  logic [3*COLOR_W-1:0] rgb_in,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic [COLOR_W-1:0]   r_out,
    output logic [COLOR_W-1:0]   g_out,
    output logic [COLOR_W-1:0]   b_out
);

    localparam int R_LSB = chan_lsb(CH_R, COLOR_W);
    localparam int G_LSB = chan_lsb(CH_G, COLOR_W);
    localparam int B_LSB = chan_lsb(CH_B, COLOR_W);

    // One extra bit so a zero back porch cannot overflow the sync-end bound.
    localparam logic [HW:0] H_ACT_END  = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0] H_SYNC_BEG = (HW+1)'(H_ACTIVE + H_FRONT);
    localparam logic [HW:0] H_SYNC_END = (HW+1)'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VW:0] V_ACT_END  = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0] V_SYNC_BEG = (VW+1)'(V_ACTIVE + V_FRONT);
    localparam logic [VW:0] V_SYNC_END = (VW+1)'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [HW-1:0]      r_h_count;
    logic [VW-1:0]      r_v_count;
    logic [FRAME_W-1:0] r_frame;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_de;
    logic [COLOR_W-1:0] r_r;
    logic [COLOR_W-1:0] r_g;
    logic [COLOR_W-1:0] r_b;

    logic [HW:0] w_h_ext;
    logic [VW:0] w_v_ext;
    sync_t       w_raw;
    sync_t       w_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_count <= '0;
            r_v_count <= '0;
            r_frame   <= '0;
        end else if (en) begin
            if (r_h_count == HW'(H_TOTAL - 1)) begin
                r_h_count <= '0;
                if (r_v_count == VW'(V_TOTAL - 1)) begin
                    r_v_count <= '0;
                    r_frame   <= r_frame + 1'b1;
                end else begin
                    r_v_count <= r_v_count + 1'b1;
                end
            end else begin
                r_h_count <= r_h_count + 1'b1;
            end
        end
    end

    assign w_h_ext  = {1'b0, r_h_count};
    assign w_v_ext  = {1'b0, r_v_count};
    assign w_raw.de = (w_h_ext < H_ACT_END) && (w_v_ext < V_ACT_END);
    assign w_raw.hs = (w_h_ext >= H_SYNC_BEG) && (w_h_ext < H_SYNC_END);
    assign w_raw.vs = (w_v_ext >= V_SYNC_BEG) && (w_v_ext < V_SYNC_END);

    assign line_start  = en && (r_h_count == '0);
    assign frame_start = line_start && (r_v_count == '0);

    vga_delay_line #(
        .WIDTH    ($bits(sync_t)),
        .DEPTH    (PIPE_LAT),
        .RESET_VAL('0)
    ) u_align (
        .clk  (clk),
        .rst_n(rst_n),
        .i_en (en),
        .i_d  (w_raw),
        .o_q  (w_dly)
    );

    // Colour is sampled in the same enabled cycle as its delayed de.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync <= ~H_POL;
            r_vsync <= ~V_POL;
            r_de    <= 1'b0;
            r_r     <= '0;
            r_g     <= '0;
            r_b     <= '0;
        end else if (en) begin
            r_hsync <= w_dly.hs ~^ H_POL;
            r_vsync <= w_dly.vs ~^ V_POL;
            r_de    <= w_dly.de;
            r_r     <= w_dly.de ? rgb_in[R_LSB +: COLOR_W] : '0;
            r_g     <= w_dly.de ? rgb_in[G_LSB +: COLOR_W] : '0;
            r_b     <= w_dly.de ? rgb_in[B_LSB +: COLOR_W] : '0;
        end
    end

    assign h_count = r_h_count;
    assign v_count = r_v_count;
    assign frame   = r_frame;
    assign hsync   = r_hsync;
    assign vsync   = r_vsync;
    assign de      = r_de;
    assign r_out   = r_r;
    assign g_out   = r_g;
    assign b_out   = r_b;

endmodule
